// File: rtl/updown_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// updown_cnt_pkg
//   Shared definitions for the up/down modulo counter:
//     DIR_UP / DIR_DOWN : encoding of the 'up' direction input
//     clog2             : prescaler register width helper (minimum 1 bit)
//     cnt_op_e          : per-edge operation chosen by the counter op decode
// ---------------------------------------------------------------------------
package updown_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..n-1; never returns less than 1 so that a
    // degenerate prescaler still has a legal register declaration.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_STEP = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_if
//   Control/status bundle of the up/down modulo counter.
//   Ports (signals):
//     en        count enable (freezes count and prescaler when low)
//     up        direction, 1 = up, 0 = down
//     load      parallel load strobe
//     load_val  value to load (clamped to MODULUS-1 by the counter)
//     count     current registered count
//     tc        registered one-cycle terminal-count pulse
//     zero      count == 0
//   Modports:
//     master : the user of the counter (drives controls, reads status)
//     slave  : the counter itself
// ---------------------------------------------------------------------------
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             zero;

    modport master (
        output en, up, load, load_val,
        input  count, tc, zero
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, zero
    );
endinterface

// File: rtl/updown_mod_counter_prescaler.sv
// ---------------------------------------------------------------------------
// cnt_prescaler
//   Divides the enabled clock into one step strobe every PRESCALE enabled
//   cycles.
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous active-high reset (clears the phase)
//     en           advance the phase; 0 freezes it
//     clr          restart the phase at 0 (used on load)
//     step_strobe  high on the enabled cycle that completes a prescale period
//   PRESCALE == 1 has no state: step_strobe simply follows en.
// ---------------------------------------------------------------------------
module cnt_prescaler
    import updown_cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step_strobe
);

    generate
        if (PRESCALE <= 1) begin : g_direct
            logic w_unused;
            assign w_unused    = ^{clk, reset, clr};
            assign step_strobe = en;
        end else begin : g_div
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] r_phase;
            logic          w_last;

            assign w_last      = (r_phase == LAST);
            assign step_strobe = en && w_last;

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    r_phase <= '0;
                end else if (en) begin
                    r_phase <= w_last ? '0 : r_phase + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   WIDTH-bit modulo-MODULUS up/down counter with parallel load, count
//   enable, clock prescaler and a registered terminal-count pulse.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (count=0, tc=0, prescaler=0)
//     bus    updown_mod_counter_if.slave (en, up, load, load_val in;
//            count, tc, zero out)
//   Parameters: WIDTH (1..32), MODULUS (2..2**WIDTH), PRESCALE (>=1).
//   Build option UPDOWN_CNT_SAT_EN: when defined the counter saturates at
//   0 / MODULUS-1 instead of wrapping; tc flags each blocked step.
//   Edge priority: reset > load > step > hold.
// ---------------------------------------------------------------------------
module updown_mod_counter
    import updown_cnt_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter longint      MODULUS  = 16,
    parameter int          PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    updown_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_step;
    cnt_op_e          w_op;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;

    // Load restarts the prescale period regardless of en.
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk         (clk),
        .reset       (reset),
        .en          (bus.en),
        .clr         (bus.load),
        .step_strobe (w_step)
    );

    always_comb begin
        w_op = CNT_HOLD;
        if (bus.load) begin
            w_op = CNT_LOAD;
        end else if (w_step) begin
            w_op = CNT_STEP;
        end
    end

    // Next-state arithmetic is modulo MODULUS: the boundary values are
    // detected explicitly rather than relying on 2**WIDTH rollover.
    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        case (w_op)
            CNT_LOAD: begin
                w_next_count = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
            end
            CNT_STEP: begin
                if (bus.up == DIR_UP) begin
                    if (r_count == MAX_VAL) begin
                        w_next_tc = 1'b1;
`ifdef UPDOWN_CNT_SAT_EN
                        w_next_count = r_count;
`else
                        w_next_count = '0;
`endif
                    end else begin
                        w_next_count = r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_next_tc = 1'b1;
`ifdef UPDOWN_CNT_SAT_EN
                        w_next_count = r_count;
`else
                        w_next_count = MAX_VAL;
`endif
                    end else begin
                        w_next_count = r_count - 1'b1;
                    end
                end
            end
            default: begin
                w_next_count = r_count;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.zero  = (r_count == '0);

endmodule
